// File: rtl/tick_timer_sched_pkg.sv
// Shared definitions for the tick timer scheduler.
// Holds the channel state encoding, timebase defaults and a width helper for the prescaler.
package tick_timer_sched_pkg;

   typedef enum logic {
      CH_IDLE = 1'b0,
      CH_RUN  = 1'b1
   } ch_state_e;

   localparam int TICK_50MS = 5000000;
   localparam int DEF_N_CH  = 4;
   localparam int DEF_DUR_W = 8;

   // Prescaler width for a 0..cycles-1 counter; cycles is at least 2, so the result is at least 1.
   function automatic int pre_width(input int cycles);
      if (cycles > 2) begin
         return $clog2(cycles);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/tick_timer_sched_if.sv
// Requester-side bundle of the tick timer scheduler.
// The master side drives the per-channel strobes; the slave side is the scheduler itself.
interface tick_timer_sched_if #(
   parameter int N_CH  = 4,
   parameter int DUR_W = 8
) ();

   logic [N_CH-1:0]       start;
   logic [N_CH-1:0]       stop;
   logic [N_CH-1:0]       reload;
   logic [N_CH*DUR_W-1:0] dur;
   logic                  tick;
   logic [N_CH-1:0]       busy;
   logic [N_CH-1:0]       done;

   modport master (
      output start,
      output stop,
      output reload,
      output dur,
      input  tick,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  stop,
      input  reload,
      input  dur,
      output tick,
      output busy,
      output done
   );

endinterface

// File: rtl/tick_timer_chan.sv
// One countdown channel: loads a duration in ticks, counts down on the shared tick,
// pulses done for one cycle on expiry and optionally reloads its last duration.
module tick_timer_chan
   import tick_timer_sched_pkg::*;
#(
   parameter int DUR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             start,
   input  logic             stop,
   input  logic             reload,
   input  logic [DUR_W-1:0] dur,
   output logic             busy,
   output logic             done
);

   localparam logic [DUR_W-1:0] CNT_ONE = DUR_W'(1);

   ch_state_e        state_r;
   logic [DUR_W-1:0] cnt_r;
   logic [DUR_W-1:0] dur_r;
   logic             rl_r;
   logic             busy_r;
   logic             done_r;

   // Channel FSM: start beats stop beats tick; busy and done are registered alongside the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= CH_IDLE;
         cnt_r   <= '0;
         dur_r   <= '0;
         rl_r    <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (start) begin
            if (dur != '0) begin
               state_r <= CH_RUN;
               busy_r  <= 1'b1;
               cnt_r   <= dur;
               dur_r   <= dur;
               rl_r    <= reload;
            end else begin
               state_r <= CH_IDLE;
               busy_r  <= 1'b0;
               cnt_r   <= '0;
               done_r  <= 1'b1;
            end
         end else begin
            case (state_r)
               CH_IDLE: begin
                  busy_r <= 1'b0;
               end
               CH_RUN: begin
                  if (stop) begin
                     state_r <= CH_IDLE;
                     busy_r  <= 1'b0;
                     cnt_r   <= '0;
                  end else if (tick) begin
                     if (cnt_r == CNT_ONE) begin
                        done_r <= 1'b1;
                        if (rl_r) begin
                           cnt_r <= dur_r;
                        end else begin
                           state_r <= CH_IDLE;
                           busy_r  <= 1'b0;
                           cnt_r   <= '0;
                        end
                     end else if (cnt_r != '0) begin
                        cnt_r <= cnt_r - CNT_ONE;
                     end else begin
                        // A zero count while running cannot be reached; fall back to idle rather than wrap.
                        state_r <= CH_IDLE;
                        busy_r  <= 1'b0;
                     end
                  end else begin
                     busy_r <= 1'b1;
                  end
               end
               default: begin
                  state_r <= CH_IDLE;
                  busy_r  <= 1'b0;
                  cnt_r   <= '0;
               end
            endcase
         end
      end
   end

   assign busy = busy_r;
   assign done = done_r;

endmodule

// File: rtl/tick_timer_sched.sv
// Shared timebase plus N_CH independent countdown timers.
// The prescaler free-runs regardless of channel activity, so start-to-first-tick jitter is up to one period.
module tick_timer_sched
   import tick_timer_sched_pkg::*;
#(
   parameter int TICK_CYCLES = TICK_50MS,
   parameter int N_CH        = DEF_N_CH,
   parameter int DUR_W       = DEF_DUR_W
) (
   input  logic                clk,
   input  logic                rst,
   tick_timer_sched_if.slave   bus
);

   localparam int            PW       = pre_width(TICK_CYCLES);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);
   localparam logic [PW-1:0] PRE_ONE  = PW'(1);

   logic [PW-1:0]   pre_r;
   logic            tick_r;
   logic [N_CH-1:0] busy_s;
   logic [N_CH-1:0] done_s;

   // Free-running prescaler; tick rises the cycle after the terminal count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_r  <= '0;
         tick_r <= 1'b0;
      end else begin
         tick_r <= (pre_r == PRE_LAST);
         if (pre_r == PRE_LAST) begin
            pre_r <= '0;
         end else begin
            pre_r <= pre_r + PRE_ONE;
         end
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      tick_timer_chan #(
         .DUR_W (DUR_W)
      ) u_chan (
         .clk    (clk),
         .rst    (rst),
         .tick   (tick_r),
         .start  (bus.start[i]),
         .stop   (bus.stop[i]),
         .reload (bus.reload[i]),
         .dur    (bus.dur[i*DUR_W +: DUR_W]),
         .busy   (busy_s[i]),
         .done   (done_s[i])
      );
   end

   assign bus.tick = tick_r;
   assign bus.busy = busy_s;
   assign bus.done = done_s;

endmodule

// File: tb/tb_tick_timer_sched.sv
// Directed and randomized bench for tick_timer_sched, checked every cycle against a
// tick-level behavioural model plus closed-form expiry times.
module tb_tick_timer_sched;

   localparam int TC = 10;
   localparam int NC = 4;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   tick_timer_sched_if #(.N_CH(NC), .DUR_W(DW)) bus ();

   tick_timer_sched #(
      .TICK_CYCLES (TC),
      .N_CH        (NC),
      .DUR_W       (DW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;   // rising edges since reset release

   logic          exp_tick = 1'b0;
   logic [NC-1:0] exp_busy = '0;
   logic [NC-1:0] exp_done = '0;

   // Model: remaining ticks per channel, running flag, reload flag, reload period.
   int rem [NC];
   bit act [NC];
   bit rlm [NC];
   int per [NC];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h at cyc %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NC; i++) begin
         rem[i] = 0;
         act[i] = 1'b0;
         rlm[i] = 1'b0;
         per[i] = 0;
      end
      exp_busy = '0;
      exp_done = '0;
   endtask

   // One clock of the channel rules, using the tick that was visible during the cycle just ended.
   task automatic model_step();
      int d;
      for (int i = 0; i < NC; i++) begin
         d = int'(bus.dur[i*DW +: DW]);
         exp_done[i] = 1'b0;
         if (bus.start[i]) begin
            if (d > 0) begin
               act[i] = 1'b1;
               rem[i] = d;
               per[i] = d;
               rlm[i] = bus.reload[i];
            end else begin
               act[i] = 1'b0;
               rem[i] = 0;
               exp_done[i] = 1'b1;
            end
         end else if (act[i] && bus.stop[i]) begin
            act[i] = 1'b0;
            rem[i] = 0;
         end else if (act[i] && exp_tick) begin
            rem[i] = rem[i] - 1;
            if (rem[i] == 0) begin
               exp_done[i] = 1'b1;
               if (rlm[i]) rem[i] = per[i];
               else        act[i] = 1'b0;
            end
         end
         exp_busy[i] = act[i];
      end
   endtask

   // Advance one edge, update the model, check all outputs 1 time unit later, then drop strobes.
   task automatic cycle();
      @(posedge clk);
      if (!rst) begin
         model_reset();
         cyc = 0;
      end else begin
         model_step();
         cyc++;
      end
      exp_tick = (rst === 1'b1) && (cyc > 0) && (cyc % TC == 0);
      #1;
      chk("tick", 32'(bus.tick), 32'(exp_tick));
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("done", 32'(bus.done), 32'(exp_done));
      bus.start = '0;
      bus.stop  = '0;
   endtask

   // Edge at which done is visible for duration d when start is taken at edge s.
   function automatic int done_edge(input int s, input int d);
      int m;
      m = ((s + TC - 1) / TC) * TC;
      return m + 1 + (d - 1) * TC;
   endfunction

   task automatic wait_done(input int ch, input int budget, output int at);
      at = -1;
      for (int k = 0; k < budget; k++) begin
         cycle();
         if (bus.done[ch] === 1'b1) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic arm(input int ch, input int d, input bit rl);
      bus.start[ch]          = 1'b1;
      bus.reload[ch]         = rl;
      bus.dur[ch*DW +: DW]   = DW'(d);
   endtask

   int s;
   int at;
   int exp_at;

   initial begin
      bus.start  = '0;
      bus.stop   = '0;
      bus.reload = '0;
      bus.dur    = '0;
      model_reset();

      // Reset held, then idle timebase.
      repeat (5) cycle();
      @(negedge clk);
      rst = 1'b1;
      repeat (12) cycle();
      chk("cyc_after_idle", 32'(cyc), 32'd12);

      // Single shot, duration 3.
      arm(0, 3, 1'b0);
      s = cyc + 1;
      cycle();
      chk("ch0_busy_next", 32'(bus.busy[0]), 32'd1);
      wait_done(0, 60, at);
      chk("ch0_latency", 32'(at), 32'(done_edge(s, 3)));
      chk("ch0_busy_drop", 32'(bus.busy[0]), 32'd0);
      cycle();
      chk("ch0_done_width", 32'(bus.done[0]), 32'd0);

      // Auto-reload, duration 2, three periods then stop.
      arm(1, 2, 1'b1);
      s = cyc + 1;
      exp_at = done_edge(s, 2);
      for (int p = 0; p < 3; p++) begin
         wait_done(1, 60, at);
         chk("ch1_period", 32'(at), 32'(exp_at));
         exp_at = exp_at + 2 * TC;
      end
      bus.stop[1] = 1'b1;
      cycle();
      chk("ch1_stopped", 32'(bus.busy[1]), 32'd0);
      repeat (30) cycle();

      // Zero duration completes at once.
      arm(2, 0, 1'b0);
      cycle();
      chk("ch2_zero_done", 32'(bus.done[2]), 32'd1);
      chk("ch2_zero_busy", 32'(bus.busy[2]), 32'd0);

      // Start on a tick cycle: that tick must not count.
      for (int k = 0; k < TC && (cyc % TC) != 0; k++) cycle();
      chk("ch3_on_tick", 32'(bus.tick), 32'd1);
      arm(3, 5, 1'b0);
      s = cyc + 1;
      wait_done(3, 80, at);
      chk("ch3_latency", 32'(at), 32'(done_edge(s, 5)));

      // Start and stop together leave the channel running; then restart with 1.
      arm(0, 6, 1'b0);
      bus.stop[0] = 1'b1;
      cycle();
      chk("start_stop_busy", 32'(bus.busy[0]), 32'd1);
      repeat (3) cycle();
      arm(0, 1, 1'b0);
      s = cyc + 1;
      wait_done(0, 40, at);
      chk("restart_latency", 32'(at), 32'(done_edge(s, 1)));

      // Simultaneous expiry on two channels.
      arm(0, 4, 1'b0);
      arm(1, 4, 1'b0);
      s = cyc + 1;
      wait_done(0, 60, at);
      chk("dual_latency", 32'(at), 32'(done_edge(s, 4)));
      chk("dual_done1", 32'(bus.done[1]), 32'd1);

      // Asynchronous reset in the middle of a count.
      arm(0, 4, 1'b0);
      arm(1, 3, 1'b1);
      repeat (15) cycle();
      #2;
      rst = 1'b0;
      #1;
      chk("async_busy", 32'(bus.busy), 32'd0);
      chk("async_done", 32'(bus.done), 32'd0);
      chk("async_tick", 32'(bus.tick), 32'd0);
      repeat (3) cycle();
      @(negedge clk);
      rst = 1'b1;
      repeat (50) cycle();

      // Randomized traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < NC; i++) begin
            if ($urandom_range(0, 39) == 0) begin
               arm(i, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 59) == 0) begin
               bus.stop[i] = 1'b1;
            end
         end
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
